clk_fbounds_param: RTL and testbench
====================================

CLK_FBOUNDS_PARAM -- requirements
Module: clk_fbounds_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning mantissa field width; W = 1+EXP_W+MAN_W, with sign at bit W-1.
REQ-003 SHALL have parameter NAN_PASS, default 1, meaning 1: NaN input passed to dout; 0: NaN replaced by low bound.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-006 SHALL have port din, input, W bits, meaning bound or sample data.
REQ-007 SHALL have port init, input, 1 bit, meaning load bounds: low on this cycle, high on the next.
REQ-008 SHALL have port start, input, 1 bit, meaning capture din as a sample and clip it.
REQ-009 SHALL have port dout, output, W bits, meaning the clipped result.
REQ-010 SHALL have ports in_bounds, below, above and is_nan, output, 1 bit each, meaning the result classification.
REQ-011 SHALL have port bnd_err, output, 1 bit, meaning the loaded high bound is less than the loaded low bound.
REQ-012 SHALL have port finished, output, 1 bit, meaning idle with the result valid.
REQ-013 SHALL drive every output directly from a flop.

Function
REQ-014 SHALL implement states IDLE, LD_HI, CMP_LO and CMP_HI in a 2-bit state register.
REQ-015 IDLE: start=1 SHALL capture din into a_reg, clear finished/in_bounds/below/above/is_nan, and go to CMP_LO.
REQ-016 IDLE: init=1 with start=0 SHALL load low_bnd<=din and go to LD_HI.
REQ-017 IDLE: start and init both 1 SHALL make start win; init is dropped.
REQ-018 LD_HI: the block SHALL load high_bnd<=din, set bnd_err<=(din < low_bnd), and return to IDLE; start and init SHALL be ignored.
REQ-019 CMP_LO, a_reg NaN: is_nan<=1 and finished<=1, then IDLE; dout<=a_reg when NAN_PASS=1, else dout<=low_bnd.
REQ-020 CMP_LO, a_reg < low_bnd: dout<=low_bnd, below<=1, finished<=1, then IDLE.
REQ-021 CMP_LO, otherwise: the block SHALL go to CMP_HI.
REQ-022 CMP_HI, high_bnd < a_reg: dout<=high_bnd, above<=1.
REQ-023 CMP_HI, otherwise: dout<=a_reg, in_bounds<=1.
REQ-024 CMP_HI SHALL always set finished<=1 and return to IDLE.
REQ-025 CMP_HI SHALL use the captured a_reg, never live din.
REQ-026 Latency: with start sampled at edge k, NaN and below results SHALL be visible after edge k+1; all other results after edge k+2.
REQ-027 start or init outside IDLE SHALL be ignored; there is no queueing and no stall output.
REQ-028 Comparison x<y SHALL use sign-magnitude ordering:
- Signs differ: x<y iff x negative, except +0 and -0, which SHALL compare equal.
- Both positive: x<y iff {exp,man}(x) < {exp,man}(y), unsigned.
- Both negative: x<y iff {exp,man}(x) > {exp,man}(y), unsigned.
REQ-029 NaN SHALL mean exp all-ones with man nonzero; infinities SHALL compare as ordinary values.
REQ-030 NaN bounds SHALL need no special handling; the result is whatever REQ-028 yields.
REQ-031 With bnd_err=1, operation SHALL proceed unchanged; the low check takes priority, so an input below low clips to low.
REQ-032 dout and the flags SHALL hold their values until the next start.
REQ-033 Exactly one of in_bounds, below, above, is_nan SHALL be 1 whenever finished=1 after a completed operation.

Reset
REQ-034 reset=1 at an edge SHALL set state=IDLE, low_bnd=0, high_bnd=0, a_reg=0, dout=0, in_bounds=below=above=is_nan=bnd_err=0, finished=1.
REQ-035 reset SHALL override start and init on the same edge.
REQ-036 reset mid-operation (LD_HI, CMP_LO or CMP_HI) SHALL abort with no partial update surviving.

Verification (defaults: EXP_W=8, MAN_W=23; bounds low=0xBF800000 (-1.0), high=0x40000000 (2.0), loaded via init)
REQ-037 start with din=0x3F800000 (1.0) -> after edge k+2: dout=0x3F800000, in_bounds=1, finished=1; finished=0 after edges k and k+1.
REQ-038 start with din=0xC0400000 (-3.0) -> after edge k+1: dout=0xBF800000, below=1, finished=1.
REQ-039 start with din=0x40800000 (4.0) -> after edge k+2: dout=0x40000000, above=1; then start with din=0x7FC00000 -> after edge k+1: dout=0x7FC00000, is_nan=1 (NAN_PASS=1), or dout=0xBF800000 (NAN_PASS=0).
REQ-040 bounds low=0x00000000, high=0x3F800000 and a=0x80000000 (-0) -> dout=0x80000000, in_bounds=1, below=0.
REQ-041 init with low=0x40000000 then high=0x3F800000 -> bnd_err=1 after the second edge; reloading low=0xBF800000, high=0x40000000 -> bnd_err=0.
REQ-042 start+init on the same edge -> sample path taken and bounds unchanged; reset asserted in CMP_HI -> all outputs at REQ-034 values on the next edge.

Source files
------------

// File: rtl/clk_fbounds_param.sv
// rtl/clk_fbounds_param.sv - clips a sign-magnitude float sample between loaded low/high bounds
module clk_fbounds_param #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int NAN_PASS = 1,
    localparam int W       = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         init,
    input  logic         start,
    output logic [W-1:0] dout,
    output logic         in_bounds,
    output logic         below,
    output logic         above,
    output logic         is_nan,
    output logic         bnd_err,
    output logic         finished
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LD_HI  = 2'd1,
        CMP_LO = 2'd2,
        CMP_HI = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] low_bnd;
    logic [W-1:0] high_bnd;
    logic [W-1:0] a_reg;
    logic         a_nan;
    logic         a_lt_low;
    logic         high_lt_a;
    logic         din_lt_low;

    // Sign-magnitude less-than; +0 and -0 compare equal.
    function automatic logic fp_lt(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-2:0] mx;
        logic [W-2:0] my;
        mx = x[W-2:0];
        my = y[W-2:0];
        if (x[W-1] != y[W-1])
            return x[W-1] && ((mx != '0) || (my != '0));
        else if (!x[W-1])
            return mx < my;
        else
            return mx > my;
    endfunction

    assign a_nan      = (&a_reg[W-2:MAN_W]) && (|a_reg[MAN_W-1:0]);
    assign a_lt_low   = fp_lt(a_reg, low_bnd);
    assign high_lt_a  = fp_lt(high_bnd, a_reg);
    assign din_lt_low = fp_lt(din, low_bnd);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = CMP_LO;
                else if (init)
                    state_nxt = LD_HI;
            end
            LD_HI:  state_nxt = IDLE;
            CMP_LO: state_nxt = (a_nan || a_lt_low) ? IDLE : CMP_HI;
            CMP_HI: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            low_bnd   <= '0;
            high_bnd  <= '0;
            a_reg     <= '0;
            dout      <= '0;
            in_bounds <= 1'b0;
            below     <= 1'b0;
            above     <= 1'b0;
            is_nan    <= 1'b0;
            bnd_err   <= 1'b0;
            finished  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= din;
                        finished  <= 1'b0;
                        in_bounds <= 1'b0;
                        below     <= 1'b0;
                        above     <= 1'b0;
                        is_nan    <= 1'b0;
                    end else if (init) begin
                        low_bnd <= din;
                    end
                end
                LD_HI: begin
                    high_bnd <= din;
                    bnd_err  <= din_lt_low;
                end
                CMP_LO: begin
                    // Low check first, so an inverted bound pair still clips low.
                    if (a_nan) begin
                        is_nan   <= 1'b1;
                        finished <= 1'b1;
                        dout     <= (NAN_PASS != 0) ? a_reg : low_bnd;
                    end else if (a_lt_low) begin
                        below    <= 1'b1;
                        finished <= 1'b1;
                        dout     <= low_bnd;
                    end
                end
                CMP_HI: begin
                    finished <= 1'b1;
                    if (high_lt_a) begin
                        above <= 1'b1;
                        dout  <= high_bnd;
                    end else begin
                        in_bounds <= 1'b1;
                        dout      <= a_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_fbounds_param.sv
// tb/tb_clk_fbounds_param.sv - randomized scoreboard bench for clk_fbounds_param
module tb_clk_fbounds_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] din = '0;
    logic        init = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dout;
    logic        in_bounds, below, above, is_nan, bnd_err, finished;

    clk_fbounds_param dut (
        .clk(clk), .reset(reset), .din(din), .init(init), .start(start),
        .dout(dout), .in_bounds(in_bounds), .below(below), .above(above),
        .is_nan(is_nan), .bnd_err(bnd_err), .finished(finished)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic [3:0]  flags;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        rst_q = 1'b1;
    logic        prev_fin = 1'b1;
    logic [31:0] m_low = '0;
    logic [31:0] m_high = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Ordering key: sign-magnitude mapped onto the signed integer line.
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic bit fnan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    always @(negedge clk) begin
        if (!rst_q && finished && !prev_fin) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("dout", dout, e.dout);
                check("flags", {in_bounds, below, above, is_nan}, e.flags);
                check("latency_cycle", cyc, e.cyc);
            end
        end
        prev_fin = finished;
    end

    task automatic do_init(input logic [31:0] lo, input logic [31:0] hi);
        @(posedge clk); #1;
        din = lo; init = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        din = hi; init = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        m_low  = lo;
        m_high = hi;
        check("bnd_err", bnd_err, fkey(hi) < fkey(lo));
        init = 1'b0; start = 1'b0; din = $urandom;
    endtask

    task automatic do_start(input logic [31:0] a, input bit with_init);
        exp_t e;
        @(posedge clk); #1;
        din = a; start = 1'b1; init = with_init;
        if (fnan(a)) begin
            e.flags = 4'b0001; e.dout = a; e.cyc = cyc + 2;
        end else if (fkey(a) < fkey(m_low)) begin
            e.flags = 4'b0100; e.dout = m_low; e.cyc = cyc + 2;
        end else if (fkey(m_high) < fkey(a)) begin
            e.flags = 4'b0010; e.dout = m_high; e.cyc = cyc + 3;
        end else begin
            e.flags = 4'b1000; e.dout = a; e.cyc = cyc + 3;
        end
        sbq.push_back(e);
        @(posedge clk); #1;
        check("finished_after_start", finished, 0);
        start = 1'($urandom_range(0, 1)); init = 1'($urandom_range(0, 1)); din = $urandom;
        @(posedge clk); #1;
        start = 1'b0; init = 1'b0; din = $urandom;
        for (int i = 0; i < 6 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            check("result_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    function automatic logic [31:0] pick(input int kind);
        case (kind)
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return m_low;
            5: return m_high;
            6: return 32'h7FC0_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_flags", {in_bounds, below, above, is_nan}, 0);
        check("rst_bnd_err", bnd_err, 0);
        check("rst_finished", finished, 1);
        reset = 1'b0;

        do_init(32'hBF80_0000, 32'h4000_0000);
        do_start(32'h3F80_0000, 0);
        do_start(32'hC040_0000, 0);
        do_start(32'h4080_0000, 0);
        do_start(32'h7FC0_0000, 0);
        do_init(32'h0000_0000, 32'h3F80_0000);
        do_start(32'h8000_0000, 0);
        do_init(32'h4000_0000, 32'h3F80_0000);
        do_start(32'h3FC0_0000, 0);
        do_start(32'h4080_0000, 0);
        do_init(32'hBF80_0000, 32'h4000_0000);
        do_start(32'h3F00_0000, 1);
        do_start(32'h3FF0_0000, 0);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 7) == 0)
                do_init(pick($urandom_range(0, 12)), pick($urandom_range(0, 12)));
            do_start(pick($urandom_range(0, 15)), bit'($urandom_range(0, 3) == 0));
        end

        do_init(32'hBF80_0000, 32'h4000_0000);
        do_start(32'hC040_0000, 0);
        @(posedge clk); #1;
        din = 32'h3F80_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_dout", dout, 0);
        check("abort_flags", {in_bounds, below, above, is_nan}, 0);
        check("abort_finished", finished, 1);
        check("abort_bnd_err", bnd_err, 0);
        reset = 1'b0;
        m_low = '0;
        m_high = '0;
        do_start(32'h3F80_0000, 0);
        do_start(32'h8000_0000, 0);

        check("queue_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
